// File: rtl/data_bus_arbiter.sv
// Round-robin two-master (core MEM / loader) arbiter and sequencer for the data memory bus.
// Optional access timeout is compiled in when DBA_TIMEOUT_EN is defined.
module data_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_be,
  output logic                  m0_done,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_be,
  output logic                  m1_done,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_err,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic                  s_we,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_be,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic                  stallreq_o
);

  localparam int unsigned BE_W = DATA_W / 8;

  // Reject configurations the bus cannot represent.
  if ((TIMEOUT < 1) || ((DATA_W % 8) != 0)) begin : g_bad_cfg
    $error("data_bus_arbiter: TIMEOUT must be >= 1 and DATA_W a multiple of 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last;

  logic              any_req_c;
  logic              winner_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic [BE_W-1:0]   sel_be_c;
  logic              timeout_hit_c;
  logic              finish_c;
  logic [DATA_W-1:0] resp_rdata_c;
  logic              resp_err_c;

  // Round-robin pick: on contention the master that did not win last time goes next.
  always_comb begin
    any_req_c   = m0_req | m1_req;
    winner_c    = (m0_req & m1_req) ? ~last : m1_req;
    sel_we_c    = winner_c ? m1_we    : m0_we;
    sel_addr_c  = winner_c ? m1_addr  : m0_addr;
    sel_wdata_c = winner_c ? m1_wdata : m0_wdata;
    sel_be_c    = winner_c ? m1_be    : m0_be;
  end

`ifdef DBA_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] tmo_cnt;

  // Counts BUS cycles without s_ready; cleared while idle so every access starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == ST_IDLE) begin
      tmo_cnt <= '0;
    end else if ((state == ST_BUS) && !s_ready) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit_c = (state == ST_BUS) && (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign resp_err_c    = ~s_ready;
`else
  assign timeout_hit_c = 1'b0;
  assign resp_err_c    = 1'b0;
`endif

  // s_ready has priority over a timeout landing in the same cycle.
  always_comb begin
    finish_c     = s_ready | timeout_hit_c;
    resp_rdata_c = (s_ready & ~s_we) ? s_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      s_valid  <= 1'b0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_be     <= '0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req_c) begin
            owner   <= winner_c;
            last    <= winner_c;
            s_we    <= sel_we_c;
            s_addr  <= sel_addr_c;
            s_wdata <= sel_wdata_c;
            s_be    <= sel_be_c;
            s_valid <= 1'b1;
            state   <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (finish_c) begin
            s_valid <= 1'b0;
            state   <= ST_RESP;
            if (owner) begin
              m1_done  <= 1'b1;
              m1_rdata <= resp_rdata_c;
              m1_err   <= resp_err_c;
            end else begin
              m0_done  <= 1'b1;
              m0_rdata <= resp_rdata_c;
              m0_err   <= resp_err_c;
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Core stall ends in the cycle its done pulse is seen.
  assign stallreq_o = m0_req & ~m0_done;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed scenarios with literal expectations, then
// randomized masters/slave checked every cycle against a transaction-level model.
module tb_data_bus_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned TIMEOUT = 16;
`ifdef DBA_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic [BE_W-1:0]   m0_be, m1_be;
  logic              m0_done, m1_done, m0_err, m1_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              s_valid, s_ready, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, s_rdata;
  logic [BE_W-1:0]   s_be;
  logic              stallreq_o;

  int checks = 0;
  int errors = 0;

  data_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_be(s_be), .s_rdata(s_rdata), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one access in flight, counted in BUS cycles.
  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } acc_t;

  bit                model_live = 1'b0;
  bit                busy, resp_due;
  int                bus_cycles, last_m, cur_m;
  acc_t              exp_s;
  logic              exp_sv;
  logic              exp_done  [2];
  logic [DATA_W-1:0] exp_rdata [2];
  logic              exp_err   [2];

  always @(posedge clk) begin
    if (rst) begin
      model_live = 1'b1;
      busy = 1'b0; resp_due = 1'b0; last_m = 1; cur_m = 0; bus_cycles = 0;
      exp_sv = 1'b0;
      exp_s = '{we: 1'b0, addr: '0, wdata: '0, be: '0};
      for (int i = 0; i < 2; i++) begin
        exp_done[i] = 1'b0; exp_rdata[i] = '0; exp_err[i] = 1'b0;
      end
    end else if (model_live) begin
      exp_done[0] = 1'b0;
      exp_done[1] = 1'b0;
      if (resp_due) begin
        resp_due = 1'b0;
      end else if (busy) begin
        bus_cycles++;
        if (s_ready || (TMO_EN && bus_cycles == int'(TIMEOUT))) begin
          busy = 1'b0; resp_due = 1'b1; exp_sv = 1'b0;
          exp_done[cur_m]  = 1'b1;
          exp_rdata[cur_m] = (s_ready && !exp_s.we) ? s_rdata : '0;
          exp_err[cur_m]   = !s_ready;
        end
      end else if (m0_req || m1_req) begin
        cur_m = (m0_req && m1_req) ? 1 - last_m : (m1_req ? 1 : 0);
        last_m = cur_m;
        busy = 1'b1; bus_cycles = 0; exp_sv = 1'b1;
        if (cur_m == 1) exp_s = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, be: m1_be};
        else            exp_s = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, be: m0_be};
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (model_live) begin
      chk("s_valid",   32'(s_valid),  32'(exp_sv));
      chk("s_we",      32'(s_we),     32'(exp_s.we));
      chk("s_addr",    s_addr,        exp_s.addr);
      chk("s_wdata",   s_wdata,       exp_s.wdata);
      chk("s_be",      32'(s_be),     32'(exp_s.be));
      chk("m0_done",   32'(m0_done),  32'(exp_done[0]));
      chk("m1_done",   32'(m1_done),  32'(exp_done[1]));
      chk("m0_rdata",  m0_rdata,      exp_rdata[0]);
      chk("m1_rdata",  m1_rdata,      exp_rdata[1]);
      chk("m0_err",    32'(m0_err),   32'(exp_err[0]));
      chk("m1_err",    32'(m1_err),   32'(exp_err[1]));
      chk("stallreq",  32'(stallreq_o), 32'(m0_req & ~exp_done[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    int exp_seq[4];
    bit seen_done;
    bit act0, act1;

    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    s_ready = 1'b0; s_rdata = '0;

    // Reset state.
    do_reset();
    #1;
    chk("rst_s_valid",  32'(s_valid),    32'h0);
    chk("rst_m0_done",  32'(m0_done),    32'h0);
    chk("rst_m1_done",  32'(m1_done),    32'h0);
    chk("rst_stallreq", 32'(stallreq_o), 32'h0);
    chk("rst_m0_rdata", m0_rdata,        32'h0);
    chk("rst_m1_rdata", m1_rdata,        32'h0);

    // Core read, slave ready in the first BUS cycle.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_1000; m0_be = 4'hF;
    s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1 chk("rd_stall_c0", 32'(stallreq_o), 32'h1);
    step(); #1;
    chk("rd_s_valid_c1", 32'(s_valid),    32'h1);
    chk("rd_s_addr_c1",  s_addr,          32'h0000_1000);
    chk("rd_stall_c1",   32'(stallreq_o), 32'h1);
    chk("rd_done_c1",    32'(m0_done),    32'h0);
    step(); #1;
    chk("rd_done_c2",    32'(m0_done),    32'h1);
    chk("rd_rdata_c2",   m0_rdata,        32'hDEAD_BEEF);
    chk("rd_stall_c2",   32'(stallreq_o), 32'h0);
    m0_req = 1'b0; s_ready = 1'b0;
    step(); #1;
    chk("rd_done_c3",    32'(m0_done),    32'h0);
    chk("rd_rdata_hold", m0_rdata,        32'hDEAD_BEEF);

    // Contention from reset: m0 first, then strict alternation while both hold req.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    s_ready = 1'b1;
    for (int c = 0; c < 30 && seq.size() < 4; c++) begin
      step(); #1;
      if (m0_done) seq.push_back(0);
      if (m1_done) seq.push_back(1);
    end
    exp_seq = '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++) begin
      if (k < seq.size()) begin
        chk("grant_order", 32'(seq[k]), 32'(exp_seq[k]));
      end else begin
        checks++; errors++;
        $display("FAIL grant_order missing grant %0d (got %0d grants)", k, seq.size());
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; s_ready = 1'b0;
    step(); step(); step();

    // Loader write with slave ready held off for 5 BUS cycles.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_2004; m1_be = 4'b0011;
    m1_wdata = 32'h0000_ABCD; s_rdata = 32'h5555_AAAA;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 6) s_ready = 1'b1;
      #1;
      chk("wr_s_valid", 32'(s_valid), 32'h1);
      chk("wr_s_addr",  s_addr,       32'h0000_2004);
      chk("wr_s_wdata", s_wdata,      32'h0000_ABCD);
      chk("wr_s_be",    32'(s_be),    32'h3);
      chk("wr_s_we",    32'(s_we),    32'h1);
    end
    step(); #1;
    chk("wr_m1_done",  32'(m1_done), 32'h1);
    chk("wr_m1_rdata", m1_rdata,     32'h0);
    chk("wr_m1_err",   32'(m1_err),  32'h0);
    m1_req = 1'b0; s_ready = 1'b0;
    step(); step();

    // Slave never answers.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_3000; s_ready = 1'b0;
    s_rdata = 32'h1234_5678;
`ifdef DBA_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      step(); #1;
      chk("tmo_s_valid_bus", 32'(s_valid), 32'h1);
    end
    step(); #1;
    chk("tmo_s_valid_drop", 32'(s_valid), 32'h0);
    chk("tmo_m0_done",      32'(m0_done), 32'h1);
    chk("tmo_m0_err",       32'(m0_err),  32'h1);
    chk("tmo_m0_rdata",     m0_rdata,     32'h0);
    m0_req = 1'b0;
    step(); step();
`else
    seen_done = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step(); #1;
      if (m0_done) seen_done = 1'b1;
    end
    chk("notmo_s_valid", 32'(s_valid),   32'h1);
    chk("notmo_no_done", 32'(seen_done), 32'h0);
    s_ready = 1'b1;
    step(); #1;
    chk("notmo_m0_done",  32'(m0_done), 32'h1);
    chk("notmo_m0_err",   32'(m0_err),  32'h0);
    chk("notmo_m0_rdata", m0_rdata,     32'h1234_5678);
    m0_req = 1'b0; s_ready = 1'b0;
    step(); step();
`endif

    // Reset in the third BUS cycle drops the access; held req is re-arbitrated.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_4000; m0_wdata = 32'h0BAD_F00D;
    s_ready = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rstbus_s_valid", 32'(s_valid), 32'h0);
    chk("rstbus_m0_done", 32'(m0_done), 32'h0);
    step(); #1;
    chk("rstbus_regrant", 32'(s_valid), 32'h1);
    chk("rstbus_s_addr",  s_addr,       32'h0000_4000);
    s_ready = 1'b1;
    step(); #1;
    chk("rstbus_done",    32'(m0_done), 32'h1);
    m0_req = 1'b0; s_ready = 1'b0;
    step(); step();

    // Randomized traffic; masters hold each access until its done pulse.
    act0 = 1'b0; act1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step();
      rst     = ($urandom_range(0, 399) == 0);
      s_ready = ($urandom_range(0, 3) == 0);
      s_rdata = $urandom;
      if (act0 && m0_done) begin act0 = 1'b0; m0_req = 1'b0; end
      if (act1 && m1_done) begin act1 = 1'b0; m1_req = 1'b0; end
      if (!act0 && $urandom_range(0, 2) == 0) begin
        act0 = 1'b1; m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1));
        m0_addr = $urandom; m0_wdata = $urandom; m0_be = 4'($urandom);
      end
      if (!act1 && $urandom_range(0, 2) == 0) begin
        act1 = 1'b1; m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1));
        m1_addr = $urandom; m1_wdata = $urandom; m1_be = 4'($urandom);
      end
    end
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; s_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
